serial_add_nbit: RTL and testbench

Bit-serial N-bit adder: the additive counterpart of the team's ripple-carry N-bit subtractor, trading area for latency. It accepts two WIDTH-bit operands and a carry-in on a start strobe, then resolves one bit per clock through a single full-adder slice and a carry flop. It returns sum, carry-out and signed overflow with a one-cycle done pulse. It sits beside the combinational ALU datapath for area-constrained or multi-cycle add paths.

---
 rtl/serial_add_nbit.sv | 130 +++++++++++++
 tb/tb_serial_add_nbit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop resolve one
// bit per clock, and sum, carry-out and signed overflow are registered on completion.
module serial_add_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH:0]   res_sh;

  // Full-adder slice on the LSBs; the concatenate-and-shift keeps WIDTH=1 legal.
  always_comb begin
    accept = start && ((state_q == IDLE) || (state_q == DONE));
    last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_bit  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    res_sh = {s_bit, res_q} >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = c_in;
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      res_d   = res_sh[WIDTH-1:0];
      carry_d = c_bit;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d   = res_sh[WIDTH-1:0];
        c_out_d = c_bit;
        ovf_d   = carry_q ^ c_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_nbit.sv
// Directed and randomized checks of serial_add_nbit at WIDTH 8, 32 and 1 against
// an arithmetic reference model.
module tb_serial_add_nbit;

  logic        clk;
  logic        rst;
  logic        cin;
  logic        start8, start32, start1;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic [0:0]  a1, b1;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;

  int total = 0;
  int bad   = 0;

  serial_add_nbit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
  );

  serial_add_nbit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .c_in(cin),
    .busy(busy32), .done(done32), .sum(sum32), .c_out(cout32), .ovf(ovf32)
  );

  serial_add_nbit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int which);
    case (which)
      0:       return 8;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic cv);
    logic [31:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic        c, o;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, av & mask} + {1'b0, bv & mask} + {32'd0, cv};
    s    = full[31:0] & mask;
    c    = full[w];
    o    = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {o, c, s};
  endfunction

  task automatic set_in(input int which, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv);
    cin = cv;
    case (which)
      0:       begin a8 = av[7:0]; b8 = bv[7:0]; end
      1:       begin a32 = av; b32 = bv; end
      default: begin a1 = av[0:0]; b1 = bv[0:0]; end
    endcase
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start8 = v;
      1:       start32 = v;
      default: start1 = v;
    endcase
  endtask

  task automatic get_out(input int which, output logic bsy, output logic dn,
                         output logic [31:0] s, output logic c, output logic o);
    case (which)
      0:       begin bsy = busy8;  dn = done8;  s = {24'd0, sum8}; c = cout8;  o = ovf8;  end
      1:       begin bsy = busy32; dn = done32; s = sum32;         c = cout32; o = ovf32; end
      default: begin bsy = busy1;  dn = done1;  s = {31'd0, sum1}; c = cout1;  o = ovf1;  end
    endcase
  endtask

  // One operation from an idle block: busy for w cycles, done on the (w+1)-th sample.
  task automatic run_op(input int which, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input bit pulse);
    int          w;
    logic [33:0] exp;
    logic        bsy, dn, c, o;
    logic [31:0] s;
    w   = wid(which);
    exp = model(w, av, bv, cv);
    set_in(which, av, bv, cv);
    set_start(which, 1'b1);
    for (int k = 1; k <= w + 2; k++) begin
      @(negedge clk);
      if (k == 1) set_start(which, 1'b0);
      if (pulse && k == 3) begin
        set_in(which, $urandom, $urandom, 1'($urandom));
        set_start(which, 1'b1);
      end
      if (pulse && k == 4) set_start(which, 1'b0);
      get_out(which, bsy, dn, s, c, o);
      if (k <= w) begin
        check("busy_run", {31'd0, bsy}, 32'd1);
        check("done_run", {31'd0, dn}, 32'd0);
      end else if (k == w + 1) begin
        check("done_pulse", {31'd0, dn}, 32'd1);
        check("busy_done", {31'd0, bsy}, 32'd0);
        check("sum", s, exp[31:0]);
        check("c_out", {31'd0, c}, {31'd0, exp[32]});
        check("ovf", {31'd0, o}, {31'd0, exp[33]});
      end else begin
        check("done_fall", {31'd0, dn}, 32'd0);
        check("busy_after", {31'd0, bsy}, 32'd0);
      end
    end
  endtask

  logic [33:0] e1, e2;
  int          n, pulses;
  logic [2:0]  combos [8];

  initial begin
    rst = 1'b1; cin = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0; a1 = '0; b1 = '0;
    start8 = 1'b1; start32 = 1'b1; start1 = 1'b1;

    // Reset held two cycles with start high.
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    check("rst_ovf", {31'd0, ovf8}, 32'd0);
    check("rst_sum32", sum32, 32'd0);
    rst = 1'b0; start8 = 1'b0; start32 = 1'b0; start1 = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done8 || done32 || done1 || busy8 || busy32 || busy1) pulses++;
    end
    check("rst_quiet", pulses, 0);

    // WIDTH=8 directed.
    run_op(0, 32'h3C, 32'h25, 1'b0, 1'b0);
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    run_op(0, 32'h7F, 32'h00, 1'b1, 1'b0);
    // WIDTH=8 random, including ignored start during RUN.
    repeat (6) run_op(0, $urandom, $urandom, 1'($urandom), 1'b0);
    repeat (3) run_op(0, $urandom, $urandom, 1'($urandom), 1'b1);

    // Mid-operation reset: no done pulse, outputs cleared.
    set_in(0, $urandom, $urandom, 1'($urandom));
    start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sum", {24'd0, sum8}, 32'd0);
    check("midrst_cout", {31'd0, cout8}, 32'd0);
    check("midrst_ovf", {31'd0, ovf8}, 32'd0);
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check("midrst_nodone", pulses, 0);

    // WIDTH=32 back-to-back with start held through DONE.
    e1 = model(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    e2 = model(32, 32'h1234_5678, 32'h0FED_CBA8, 1'b0);
    set_in(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    start32 = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done32) begin n = k; break; end
    end
    check("b2b_lat1", n, 33);
    check("b2b_sum1", sum32, e1[31:0]);
    check("b2b_cout1", {31'd0, cout32}, {31'd0, e1[32]});
    check("b2b_ovf1", {31'd0, ovf32}, {31'd0, e1[33]});
    set_in(1, 32'h1234_5678, 32'h0FED_CBA8, 1'b0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start32 = 1'b0;
        check("b2b_nogap", {31'd0, busy32}, 32'd1);
      end
      if (done32) begin n = k; break; end
    end
    check("b2b_gap", n, 33);
    check("b2b_sum2", sum32, e2[31:0]);
    check("b2b_cout2", {31'd0, cout32}, {31'd0, e2[32]});
    check("b2b_ovf2", {31'd0, ovf32}, {31'd0, e2[33]});
    @(negedge clk);
    repeat (2) run_op(1, $urandom, $urandom, 1'($urandom), 1'b0);

    // WIDTH=1 sweep of all combinations in shuffled order.
    for (int i = 0; i < 8; i++) combos[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      int          j;
      logic [2:0]  t;
      j = int'($urandom_range(i, 0));
      t = combos[i]; combos[i] = combos[j]; combos[j] = t;
    end
    for (int i = 0; i < 8; i++)
      run_op(2, {31'd0, combos[i][2]}, {31'd0, combos[i][1]}, combos[i][0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
